dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_if.sv | 29 ++
 rtl/dmem_responder.sv | 134 +++++++++++++
 tb/tb_dmem_responder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// Core-to-data-memory handshake: request/address/data from the core, read data and stall back.
interface dmem_if;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        ram_stall;

  // Core side
  modport master (
    output mem_ren,
    output mem_wen,
    output mem_addr,
    output mem_dout,
    input  mem_din,
    input  ram_stall
  );

  // Memory side
  modport slave (
    input  mem_ren,
    input  mem_wen,
    input  mem_addr,
    input  mem_dout,
    output mem_din,
    output ram_stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data memory: stalls the core for LATENCY cycles per access,
// then commits the write or latches the read word on the edge entering DONE.
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 32;

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("dmem_responder: LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_d;
  logic [DATA_W-1:0]       din_q;
  logic                    stall_c;
  logic                    complete_c;
  logic                    req_c;
  logic                    is_write_c;
  logic [ADDR_WIDTH-1:0]   word_idx_c;
  logic [DATA_W-1:0]       mem [DEPTH];

  // Byte offset and address bits above the array depth are don't-care (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_addr[1:0], bus.mem_addr[31:ADDR_WIDTH+2]};

  assign req_c      = bus.mem_ren | bus.mem_wen;
  assign is_write_c = bus.mem_wen;
  assign word_idx_c = bus.mem_addr[ADDR_WIDTH+1:2];

  // Next-state, counter and stall; complete_c marks the edge entering DONE.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stall_c    = 1'b0;
    complete_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_c) begin
          stall_c = 1'b1;
          cnt_d   = CNT_W'(LATENCY - 1);
          if (LATENCY > 1) begin
            state_d = WAIT;
          end else begin
            state_d    = DONE;
            complete_c = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!req_c) begin
          // Core flushed the request: abandon without touching array or read data.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d    = DONE;
            complete_c = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Reset wins over everything, including an access due to complete this edge.
    if (rst) begin
      stall_c    = 1'b0;
      complete_c = 1'b0;
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read data register: loads only when a read completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= '0;
    end else if (complete_c && !is_write_c) begin
      din_q <= mem[word_idx_c];
    end
  end

  // Storage array: not reset, written only when a write completes.
  always_ff @(posedge clk) begin
    if (complete_c && is_write_c) begin
      mem[word_idx_c] <= bus.mem_dout;
    end
  end

  assign bus.mem_din   = din_q;
  assign bus.ram_stall = stall_c;

  // The stall counter never sits at zero while waiting.
  a_wait_cnt_nonzero : assert property (
    @(posedge clk) disable iff (rst) (state_q == WAIT) |-> (cnt_q != '0)
  );

  // The DONE cycle never stalls.
  a_done_no_stall : assert property (
    @(posedge clk) disable iff (rst) (state_q == DONE) |-> !stall_c
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at LATENCY 1, 2 and 3.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_vec = 0;
  int n_err = 0;

  // Per-instance stimulus and observation (0: LATENCY=1, 1: LATENCY=2, 2: LATENCY=3)
  logic        ren   [3];
  logic        wen   [3];
  logic [31:0] addr  [3];
  logic [31:0] dout  [3];
  logic [31:0] din_w [3];
  logic        stall_w [3];

  dmem_if bus0 ();
  dmem_if bus1 ();
  dmem_if bus2 ();

  assign bus0.mem_ren  = ren[0];
  assign bus0.mem_wen  = wen[0];
  assign bus0.mem_addr = addr[0];
  assign bus0.mem_dout = dout[0];
  assign din_w[0]      = bus0.mem_din;
  assign stall_w[0]    = bus0.ram_stall;

  assign bus1.mem_ren  = ren[1];
  assign bus1.mem_wen  = wen[1];
  assign bus1.mem_addr = addr[1];
  assign bus1.mem_dout = dout[1];
  assign din_w[1]      = bus1.mem_din;
  assign stall_w[1]    = bus1.ram_stall;

  assign bus2.mem_ren  = ren[2];
  assign bus2.mem_wen  = wen[2];
  assign bus2.mem_addr = addr[2];
  assign bus2.mem_dout = dout[2];
  assign din_w[2]      = bus2.mem_din;
  assign stall_w[2]    = bus2.ram_stall;

  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_l1 (.clk(clk), .rst(rst), .bus(bus0));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_l2 (.clk(clk), .rst(rst), .bus(bus1));
  dmem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut_l3 (.clk(clk), .rst(rst), .bus(bus2));

  always #5 clk = ~clk;

  // Count one comparison and report it if it misses.
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request from IDLE, check LATENCY stall cycles then the non-stalled DONE
  // cycle; the request stays asserted through DONE as a real core would hold it.
  task automatic access(input int d, input bit re, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input int lat, input string tag,
                        output logic [31:0] din_done);
    ren[d]  = re;
    wen[d]  = we;
    addr[d] = a;
    dout[d] = wd;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk($sformatf("%s_stall%0d", tag, i), 32'(stall_w[d]), 32'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk($sformatf("%s_done_stall", tag), 32'(stall_w[d]), 32'h0);
    din_done = din_w[d];
    @(posedge clk); #1;
  endtask

  // One cycle with no request.
  task automatic idle(input int d, input string tag);
    ren[d] = 1'b0;
    wen[d] = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_idle_stall", tag), 32'(stall_w[d]), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 3; i++) begin
      ren[i]  = 1'b0;
      wen[i]  = 1'b0;
      addr[i] = '0;
      dout[i] = '0;
    end

    // Reset: outputs cleared, and a request during reset must not stall.
    repeat (2) @(posedge clk);
    #1;
    ren[1] = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_din%0d", i), din_w[i], 32'h0);
      chk($sformatf("rst_stall%0d", i), 32'(stall_w[i]), 32'h0);
    end
    @(posedge clk); #1;
    ren[1] = 1'b0;
    rst    = 1'b0;
    for (int i = 0; i < 3; i++) idle(i, "post_rst");

    // LATENCY=1: preload, then back-to-back reads give stall 1,0,1,0.
    access(0, 1'b0, 1'b1, 32'h4, 32'h11, 1, "l1_wr4", d);
    chk("l1_wr4_din", d, 32'h0);
    access(0, 1'b0, 1'b1, 32'h8, 32'h22, 1, "l1_wr8", d);
    idle(0, "l1");
    access(0, 1'b1, 1'b0, 32'h4, 32'h0, 1, "l1_rd4", d);
    chk("l1_rd4_din", d, 32'h11);
    access(0, 1'b1, 1'b0, 32'h8, 32'h0, 1, "l1_rd8", d);
    chk("l1_rd8_din", d, 32'h22);
    idle(0, "l1");
    @(negedge clk);
    chk("l1_din_hold", din_w[0], 32'h22);
    @(posedge clk); #1;

    // LATENCY=3: write dropped in its second stall cycle is discarded.
    access(2, 1'b0, 1'b1, 32'h20, 32'h7777_7777, 3, "l3_wr20", d);
    idle(2, "l3");
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 3, "l3_rd20a", d);
    chk("l3_rd20a_din", d, 32'h7777_7777);
    idle(2, "l3");
    wen[2]  = 1'b1;
    addr[2] = 32'h20;
    dout[2] = 32'h5A5A_5A5A;
    @(negedge clk);
    chk("l3_abort_stall0", 32'(stall_w[2]), 32'h1);
    @(posedge clk); #1;
    wen[2] = 1'b0;
    @(negedge clk);
    chk("l3_abort_fall", 32'(stall_w[2]), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("l3_abort_idle", 32'(stall_w[2]), 32'h0);
    chk("l3_abort_din", din_w[2], 32'h7777_7777);
    @(posedge clk); #1;
    access(2, 1'b1, 1'b0, 32'h20, 32'h0, 3, "l3_rd20b", d);
    chk("l3_rd20b_din", d, 32'h7777_7777);
    idle(2, "l3");

    // LATENCY=2: write/read, same-address back-to-back read is a fresh access.
    access(1, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2, "l2_wr10", d);
    idle(1, "l2");
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 2, "l2_rd10a", d);
    chk("l2_rd10a_din", d, 32'hDEAD_BEEF);
    access(1, 1'b1, 1'b0, 32'h10, 32'h0, 2, "l2_rd10b", d);
    chk("l2_rd10b_din", d, 32'hDEAD_BEEF);
    idle(1, "l2");

    // Address wrap: 0x1004 and 0x6 both select word 1.
    access(1, 1'b0, 1'b1, 32'h0000_1004, 32'h1234, 2, "l2_wr1004", d);
    idle(1, "l2");
    access(1, 1'b1, 1'b0, 32'h0000_0006, 32'h0, 2, "l2_rd6", d);
    chk("l2_rd6_din", d, 32'h1234);
    idle(1, "l2");

    // Read and write together is a write: array updated, read data untouched.
    access(1, 1'b1, 1'b1, 32'h40, 32'hCAFE, 2, "l2_rw40", d);
    chk("l2_rw40_din", d, 32'h1234);
    idle(1, "l2");
    access(1, 1'b1, 1'b0, 32'h40, 32'h0, 2, "l2_rd40", d);
    chk("l2_rd40_din", d, 32'hCAFE);
    idle(1, "l2");

    // Reset pulsed in WAIT of a write to 0x30, on what would be its completing edge.
    access(1, 1'b0, 1'b1, 32'h30, 32'h3030_3030, 2, "l2_wr30", d);
    idle(1, "l2");
    wen[1]  = 1'b1;
    addr[1] = 32'h30;
    dout[1] = 32'hBAD0_BAD0;
    @(negedge clk);
    chk("l2_rstw_stall0", 32'(stall_w[1]), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("l2_rstw_stall_rst", 32'(stall_w[1]), 32'h0);
    @(posedge clk); #1;
    rst    = 1'b0;
    wen[1] = 1'b0;
    @(negedge clk);
    chk("l2_rstw_din", din_w[1], 32'h0);
    chk("l2_rstw_stall", 32'(stall_w[1]), 32'h0);
    @(posedge clk); #1;
    access(1, 1'b1, 1'b0, 32'h30, 32'h0, 2, "l2_rd30", d);
    chk("l2_rd30_din", d, 32'h3030_3030);
    idle(1, "l2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
